// File: rtl/fan_mode_controller.sv
// Fan speed controller: 4-state speed FSM selects one comparator PWM level,
// with an auto-off countdown timer that returns the fan to STOP on expiry.
module fan_mode_controller #(
  parameter int SEC_CYCLES  = 100_000_000,
  parameter int STEP_SEC    = 60,
  parameter int TIMER_STEPS = 3
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_speed,
  input  logic       i_btn_timer,
  input  logic       i_btn_off,
  input  logic       i_fan_0,
  input  logic       i_fan_1,
  input  logic       i_fan_2,
  input  logic       i_fan_3,
  output logic       o_pwm,
  output logic [1:0] o_mode,
  output logic [3:0] o_mode_led,
  output logic [7:0] o_timer_sec,
  output logic       o_timer_active
);

  localparam int              PW         = $clog2(SEC_CYCLES);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SEC_CYCLES - 1);
  localparam logic [8:0]      STEP       = 9'(STEP_SEC);
  localparam logic [8:0]      MAX_SEC    = 9'(STEP_SEC * TIMER_STEPS);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_LOW  = 2'd1,
    ST_MID  = 2'd2,
    ST_HIGH = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [7:0]    r_remaining;
  logic [7:0]    w_next_remaining;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_next_presc;
  logic          w_tick;
  logic [8:0]    w_sum;
  logic          w_fan_sel;
  logic          r_pwm;
  logic [3:0]    r_mode_led;
  logic          r_timer_active;

  assign w_tick = (r_remaining != 8'd0) && (r_presc == PRESC_LAST);

  // Priority: off > expiry > speed > timer; timer is judged against the post-speed state.
  always_comb begin
    w_next_state     = r_state;
    w_next_remaining = r_remaining;
    w_next_presc     = r_presc;
    w_sum            = 9'd0;
    if (i_btn_off) begin
      w_next_state     = ST_STOP;
      w_next_remaining = 8'd0;
      w_next_presc     = '0;
    end else if (w_tick && (r_remaining == 8'd1)) begin
      w_next_state     = ST_STOP;
      w_next_remaining = 8'd0;
      w_next_presc     = '0;
    end else begin
      if (r_remaining != 8'd0) begin
        if (w_tick) begin
          w_next_remaining = r_remaining - 8'd1;
          w_next_presc     = '0;
        end else begin
          w_next_presc = r_presc + PW'(1);
        end
      end
      if (i_btn_speed) begin
        case (r_state)
          ST_STOP: w_next_state = ST_LOW;
          ST_LOW:  w_next_state = ST_MID;
          ST_MID:  w_next_state = ST_HIGH;
          default: w_next_state = ST_STOP;
        endcase
        if (w_next_state == ST_STOP) begin
          w_next_remaining = 8'd0;
          w_next_presc     = '0;
        end
      end
      if (i_btn_timer && (w_next_state != ST_STOP)) begin
        w_sum = {1'b0, w_next_remaining} + STEP;
        if (w_sum > MAX_SEC) begin
          w_next_remaining = 8'd0;
          w_next_presc     = '0;
        end else begin
          // Only a fresh load restarts the second prescaler.
          if (w_next_remaining == 8'd0) begin
            w_next_presc = '0;
          end
          w_next_remaining = w_sum[7:0];
        end
      end
    end
  end

  always_comb begin
    w_fan_sel = 1'b0;
    case (r_state)
      ST_STOP: w_fan_sel = i_fan_0;
      ST_LOW:  w_fan_sel = i_fan_1;
      ST_MID:  w_fan_sel = i_fan_2;
      default: w_fan_sel = i_fan_3;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= ST_STOP;
      r_remaining    <= 8'd0;
      r_presc        <= '0;
      r_pwm          <= 1'b0;
      r_mode_led     <= 4'b0001;
      r_timer_active <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_remaining    <= w_next_remaining;
      r_presc        <= w_next_presc;
      r_pwm          <= w_fan_sel;
      r_mode_led     <= 4'(4'b0001 << w_next_state);
      r_timer_active <= (w_next_remaining != 8'd0);
    end
  end

  assign o_pwm          = r_pwm;
  assign o_mode         = r_state;
  assign o_mode_led     = r_mode_led;
  assign o_timer_sec    = r_remaining;
  assign o_timer_active = r_timer_active;

endmodule

// File: tb/tb_fan_mode_controller.sv
// Self-checking bench for fan_mode_controller: directed scenarios followed by
// random button/fan traffic, all compared against a behavioural model.
module tb_fan_mode_controller;

  localparam int SEC   = 10;
  localparam int STEP  = 2;
  localparam int STEPS = 3;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_btn_speed, i_btn_timer, i_btn_off;
  logic       i_fan_0, i_fan_1, i_fan_2, i_fan_3;
  logic       o_pwm;
  logic [1:0] o_mode;
  logic [3:0] o_mode_led;
  logic [7:0] o_timer_sec;
  logic       o_timer_active;

  int total = 0;
  int bad   = 0;

  // Reference model: mode number, seconds left, cycles elapsed in current second.
  int         mMode;
  int         mRem;
  int         mCyc;
  logic       mPwm;
  logic [3:0] curFan;

  fan_mode_controller #(
    .SEC_CYCLES (SEC),
    .STEP_SEC   (STEP),
    .TIMER_STEPS(STEPS)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_btn_speed   (i_btn_speed),
    .i_btn_timer   (i_btn_timer),
    .i_btn_off     (i_btn_off),
    .i_fan_0       (i_fan_0),
    .i_fan_1       (i_fan_1),
    .i_fan_2       (i_fan_2),
    .i_fan_3       (i_fan_3),
    .o_pwm         (o_pwm),
    .o_mode        (o_mode),
    .o_mode_led    (o_mode_led),
    .o_timer_sec   (o_timer_sec),
    .o_timer_active(o_timer_active)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    mMode = 0;
    mRem  = 0;
    mCyc  = 0;
    mPwm  = 1'b0;
  endtask

  task automatic modelStep(input logic spd, input logic tmr, input logic off, input logic [3:0] fan);
    bit tick;
    mPwm = fan[mMode];
    tick = (mRem != 0) && (mCyc == SEC - 1);
    if (off) begin
      mMode = 0; mRem = 0; mCyc = 0;
    end else if (tick && mRem == 1) begin
      mMode = 0; mRem = 0; mCyc = 0;
    end else begin
      if (mRem != 0) begin
        if (tick) begin
          mRem = mRem - 1;
          mCyc = 0;
        end else begin
          mCyc = mCyc + 1;
        end
      end
      if (spd) begin
        mMode = (mMode + 1) % 4;
        if (mMode == 0) begin
          mRem = 0; mCyc = 0;
        end
      end
      if (tmr && mMode != 0) begin
        if (mRem + STEP > STEP * STEPS) begin
          mRem = 0; mCyc = 0;
        end else begin
          if (mRem == 0) mCyc = 0;
          mRem = mRem + STEP;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".mode"},   32'(o_mode),         32'(mMode));
    checkVal({tag, ".led"},    32'(o_mode_led),     32'(1 << mMode));
    checkVal({tag, ".sec"},    32'(o_timer_sec),    32'(mRem));
    checkVal({tag, ".active"}, 32'(o_timer_active), 32'(mRem != 0));
    checkVal({tag, ".pwm"},    32'(o_pwm),          32'(mPwm));
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic applyStimulus(input logic spd, input logic tmr, input logic off, input logic [3:0] fan);
    curFan      = fan;
    i_btn_speed = spd;
    i_btn_timer = tmr;
    i_btn_off   = off;
    {i_fan_3, i_fan_2, i_fan_1, i_fan_0} = fan;
    @(posedge i_clk);
    modelStep(spd, tmr, off, fan);
    #1;
    i_btn_speed = 1'b0;
    i_btn_timer = 1'b0;
    i_btn_off   = 1'b0;
    checkOutput("cyc");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, curFan);
  endtask

  task automatic doReset();
    #3;
    i_reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset");
    checkVal("reset.led_const", 32'(o_mode_led), 32'd1);
    @(posedge i_clk);
    #1;
    checkOutput("reset_hold");
    #3;
    i_reset_n = 1'b1;
  endtask

  initial begin
    i_reset_n   = 1'b1;
    i_btn_speed = 1'b0;
    i_btn_timer = 1'b0;
    i_btn_off   = 1'b0;
    curFan      = 4'b0000;
    {i_fan_3, i_fan_2, i_fan_1, i_fan_0} = 4'b0000;
    modelReset();
    @(posedge i_clk);
    #1;
    doReset();

    // Speed cycling through all four modes.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    checkVal("spd.low", 32'(o_mode_led), 32'h2);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    checkVal("spd.mid", 32'(o_mode_led), 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1010);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1010);
    checkVal("mid.pwm_lo", 32'(o_pwm), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100);
    checkVal("mid.pwm_hi", 32'(o_pwm), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    checkVal("spd.high", 32'(o_mode), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    checkVal("spd.wrap", 32'(o_mode_led), 32'h1);

    // Single timer step in LOW runs out after exactly 2*SEC cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010);
    checkVal("tmr.load", 32'(o_timer_sec), 32'd2);
    idle(10);
    checkVal("tmr.sec1", 32'(o_timer_sec), 32'd1);
    idle(9);
    checkVal("tmr.pre_exp", 32'(o_mode), 32'd1);
    idle(1);
    checkVal("tmr.expired_sec", 32'(o_timer_sec), 32'd0);
    checkVal("tmr.expired_mode", 32'(o_mode), 32'd0);

    // Timer stepping and cancel in HIGH, ignored in STOP.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 4'b1000);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1000);
    checkVal("step.2", 32'(o_timer_sec), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1000);
    checkVal("step.4", 32'(o_timer_sec), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1000);
    checkVal("step.6", 32'(o_timer_sec), 32'd6);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1000);
    checkVal("step.cancel", 32'(o_timer_sec), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
    checkVal("stop.timer_ignored", 32'(o_timer_sec), 32'd0);

    // Off beats speed; speed on the expiry tick is lost.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010);
    idle(3);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0010);
    checkVal("off.mode", 32'(o_mode), 32'd0);
    checkVal("off.sec", 32'(o_timer_sec), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010);
    idle(19);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010);
    checkVal("exp_spd.mode", 32'(o_mode), 32'd0);
    idle(1);
    checkVal("exp_spd.after", 32'(o_mode), 32'd0);

    // Reset in the middle of a MID countdown, then a fresh LOW run.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0100);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0100);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0100);
    checkVal("mid.sec4", 32'(o_timer_sec), 32'd4);
    idle(3);
    doReset();
    checkVal("rst.sec", 32'(o_timer_sec), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010);
    idle(19);
    checkVal("rerun.pre", 32'(o_mode), 32'd1);
    idle(1);
    checkVal("rerun.exp", 32'(o_mode), 32'd0);

    // Random button and comparator traffic.
    for (int k = 0; k < 800; k++) begin
      applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
